// File: rtl/mvm_pkg.sv
// Shared constants, types and FSM encoding for the MVM result drain.
//   K      elements per result vector
//   B      multiplier operand width (result width is 2*B)
//   OUT_W  signed output element width
//   SHIFT  rounding right shift applied before saturation
package mvm_pkg;
  localparam int K     = 32;
  localparam int B     = 8;
  localparam int OUT_W = 8;
  localparam int SHIFT = 4;
  localparam int IDX_W = $clog2(K);

  typedef logic signed [2*B-1:0]   acc_t;
  typedef logic signed [OUT_W-1:0] elem_t;
  typedef logic [IDX_W-1:0]        idx_t;

  typedef enum logic [1:0] {IDLE, ALIGN, CAPTURE} drain_state_t;
endpackage

// File: rtl/mvm_requant.sv
// Combinational requantizer: optional ReLU, round-half-up arithmetic right
// shift by SHIFT, then saturation to the signed OUT_W range.
//   din   acc_t  raw multiplier result
//   dout  elem_t requantized element
module mvm_requant
  import mvm_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  acc_t  din,
  output elem_t dout
);
  // One guard bit so the rounding add can never wrap.
  localparam int WW = 2*B + 1;
  localparam logic signed [WW-1:0] MAXV = WW'((1 << (OUT_W-1)) - 1);
  localparam logic signed [WW-1:0] MINV = -MAXV - WW'(1);

  logic signed [WW-1:0] v, r;

  always_comb begin
    v = {din[2*B-1], din};
    if (RELU && din[2*B-1]) v = '0;
  end

  generate
    if (SHIFT > 0) begin : g_shift
      localparam logic signed [WW-1:0] RND = WW'(1 << (SHIFT-1));
      assign r = (v + RND) >>> SHIFT;
    end else begin : g_noshift
      assign r = v;
    end
  endgenerate

  always_comb begin
    if (r > MAXV)      dout = MAXV[OUT_W-1:0];
    else if (r < MINV) dout = MINV[OUT_W-1:0];
    else               dout = r[OUT_W-1:0];
  end
endmodule

// File: rtl/mvm_result_drain.sv
// Captures the K-element result vector streamed by the MVM unit after done,
// requantizes each element and buffers it in a K-deep FIFO drained over a
// valid/ready stream.
//   clk, reset        clock (rising), async active-low reset
//   mvm_done          done from the multiplier (rising edge starts capture)
//   mvm_data          signed multiplier data_out
//   out_valid/ready   output handshake
//   out_data          requantized element at FIFO head
//   out_idx/out_last  element index within its vector, last flag
//   busy              capture in progress
//   err_overrun       sticky: a result vector was dropped
module mvm_result_drain
  import mvm_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  mvm_done,
  input  acc_t  mvm_data,
  output logic  out_valid,
  input  logic  out_ready,
  output elem_t out_data,
  output idx_t  out_idx,
  output logic  out_last,
  output logic  busy,
  output logic  err_overrun
);
  localparam int CNT_W = $clog2(K+1);

  drain_state_t state, state_nxt;
  idx_t         cnt;
  logic         done_q, done_rise;
  logic         push, pop, overrun;
  elem_t        rq;

  logic [CNT_W-1:0] count;
  idx_t             wr_ptr, rd_ptr;
  elem_t            mem_data [K];
  idx_t             mem_idx  [K];

  mvm_requant #(.RELU(RELU)) u_rq (.din(mvm_data), .dout(rq));

  assign done_rise = mvm_done && !done_q;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    overrun   = 1'b0;
    case (state)
      IDLE: begin
        // A whole vector must fit, so admission requires an empty FIFO.
        if (done_rise) begin
          if (count == '0) state_nxt = ALIGN;
          else             overrun   = 1'b1;
        end
      end
      ALIGN: begin
        overrun   = done_rise;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        overrun = done_rise;
        push    = 1'b1;
        if (cnt == idx_t'(K-1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      cnt         <= '0;
      err_overrun <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= mvm_done;
      if (overrun) err_overrun <= 1'b1;
      if (push) cnt <= (cnt == idx_t'(K-1)) ? '0 : cnt + 1'b1;
      else      cnt <= '0;
      if (push) wr_ptr <= (wr_ptr == idx_t'(K-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == idx_t'(K-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read unless count says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= rq;
      mem_idx[wr_ptr]  <= cnt;
    end
  end

  // Head entry is masked while empty so outputs read 0 out of reset.
  assign out_data = out_valid ? mem_data[rd_ptr] : '0;
  assign out_idx  = out_valid ? mem_idx[rd_ptr]  : '0;
  assign out_last = out_valid && (mem_idx[rd_ptr] == idx_t'(K-1));

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && count == CNT_W'(K)));
endmodule
